// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared types, opcodes and the default branch-target ROM image.
package pc_sequencer_pkg;

    localparam int kPcW   = 10;
    localparam int kLutAw = 5;
    localparam int kLutN  = 1 << kLutAw;
    localparam int kCntW  = 16;

    localparam logic [3:0] kBEQ  = 4'h8;
    localparam logic [3:0] kBNE  = 4'h9;
    localparam logic [3:0] kHALT = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} seq_state_t;

    // Program image for the branch-target ROM; unlisted entries read 0.
    function automatic logic [kLutN-1:0][kPcW-1:0] default_lut();
        logic [kLutN-1:0][kPcW-1:0] t;
        t    = '0;
        t[1] = 10'h3FF;
        t[2] = 10'h012;
        t[3] = 10'h040;
        t[4] = 10'h020;
        return t;
    endfunction

    localparam logic [kLutN-1:0][kPcW-1:0] kBranchLut = default_lut();

endpackage

// File: rtl/pc_sequencer_branch_lut.sv
// branch_lut: constant branch-target ROM with a combinational read.
//   br_idx_i  in   LUT_AW  target index taken from the instruction field
//   target_o  out  PC_W    absolute branch target
module branch_lut
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W   = kPcW,
    parameter int LUT_AW = kLutAw,
    parameter logic [(1<<LUT_AW)-1:0][PC_W-1:0] TABLE = kBranchLut
) (
    input  logic [LUT_AW-1:0] br_idx_i,
    output logic [PC_W-1:0]   target_o
);
    assign target_o = TABLE[br_idx_i];
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter / fetch sequencer with START/DONE handshake and run statistics.
//   clk_i, reset_i         clock, synchronous active-high reset
//   start_i                level; holds the core idle while high
//   halt_i, br_en_i        decoder flags for the current instruction
//   br_idx_i, b_taken_i    branch-target index and ALU branch result
//   pc_o                   instruction-memory address
//   running_o, done_o      state decodes (RUN, HALTED)
//   cycle_ct_o, taken_ct_o saturating RUN-cycle and taken-branch counters
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W   = kPcW,
    parameter int LUT_AW = kLutAw,
    parameter int CNT_W  = kCntW
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              halt_i,
    input  logic              br_en_i,
    input  logic [LUT_AW-1:0] br_idx_i,
    input  logic              b_taken_i,
    output logic [PC_W-1:0]   pc_o,
    output logic              running_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  cycle_ct_o,
    output logic [CNT_W-1:0]  taken_ct_o
);
    seq_state_t       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d, target;
    logic [CNT_W-1:0] cycle_q, cycle_d, taken_q, taken_d;
    logic             in_idle, in_run, adv, taken;

    branch_lut #(.PC_W(PC_W), .LUT_AW(LUT_AW)) u_lut (
        .br_idx_i (br_idx_i),
        .target_o (target)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cycle_q <= '0;
            taken_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cycle_q <= cycle_d;
            taken_q <= taken_d;
        end
    end

    always_comb begin
        state_d = start_i ? S_IDLE :
                  (state_q == S_IDLE) ? S_RUN :
                  (state_q == S_RUN && halt_i) ? S_HALTED : state_q;
    end

    always_comb begin
        in_idle = (state_q == S_IDLE);
        in_run  = (state_q == S_RUN);
        // adv: a RUN cycle not pre-empted by restart; it is counted even when halting
        adv     = in_run && !start_i;
        taken   = adv && !halt_i && br_en_i && b_taken_i;
        pc_d    = (start_i || in_idle) ? '0 :
                  !adv ? pc_q :
                  halt_i ? pc_q :
                  taken ? target : pc_q + 1'b1;
        // Counters clear for the whole IDLE stay, so a new run always starts from zero
        cycle_d = in_idle ? '0 : (adv && !(&cycle_q)) ? cycle_q + 1'b1 : cycle_q;
        taken_d = in_idle ? '0 : (taken && !(&taken_q)) ? taken_q + 1'b1 : taken_q;
    end

    always_comb begin
        running_o = (state_q == S_RUN);
        done_o    = (state_q == S_HALTED);
    end

    assign pc_o       = pc_q;
    assign cycle_ct_o = cycle_q;
    assign taken_ct_o = taken_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench with a cycle-level reference model for pc_sequencer.
module tb_pc_sequencer;
    logic       clk = 1'b0;
    logic       reset, start, halt, br_en, b_taken;
    logic [4:0] br_idx;
    logic [9:0] pc, pc4;
    logic       running, done, running4, done4;
    logic [15:0] cyc, tk;
    logic [3:0]  cyc4, tk4;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_sequencer u_dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .halt_i(halt),
        .br_en_i(br_en), .br_idx_i(br_idx), .b_taken_i(b_taken),
        .pc_o(pc), .running_o(running), .done_o(done),
        .cycle_ct_o(cyc), .taken_ct_o(tk)
    );

    pc_sequencer #(.CNT_W(4)) u_dut4 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .halt_i(halt),
        .br_en_i(br_en), .br_idx_i(br_idx), .b_taken_i(b_taken),
        .pc_o(pc4), .running_o(running4), .done_o(done4),
        .cycle_ct_o(cyc4), .taken_ct_o(tk4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: program memory of branch targets, plain integer state
    function automatic int lut_of(input int i);
        case (i)
            1:       return 'h3FF;
            2:       return 'h012;
            3:       return 'h040;
            4:       return 'h020;
            default: return 0;
        endcase
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    int  m_mode;  // 0 idle, 1 run, 2 halted
    int  m_pc, m_cyc, m_tk;
    bit  armed = 1'b0;

    always @(posedge clk) begin
        armed = 1'b1;
        if (reset) begin
            m_mode = 0; m_pc = 0; m_cyc = 0; m_tk = 0;
        end else if (m_mode == 0) begin
            m_pc = 0; m_cyc = 0; m_tk = 0;
            if (!start) m_mode = 1;
        end else if (start) begin
            m_mode = 0; m_pc = 0;
        end else if (m_mode == 1) begin
            m_cyc++;
            if (halt) m_mode = 2;
            else if (br_en && b_taken) begin
                m_pc = lut_of(int'(br_idx));
                m_tk++;
            end else m_pc = (m_pc + 1) % 1024;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("model_pc", 32'(pc), 32'(m_pc));
            check("model_running", 32'(running), 32'(m_mode == 1));
            check("model_done", 32'(done), 32'(m_mode == 2));
            check("model_cycle", 32'(cyc), 32'(sat(m_cyc, 65535)));
            check("model_taken", 32'(tk), 32'(sat(m_tk, 65535)));
            check("model4_pc", 32'(pc4), 32'(m_pc));
            check("model4_cycle", 32'(cyc4), 32'(sat(m_cyc, 15)));
            check("model4_taken", 32'(tk4), 32'(sat(m_tk, 15)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; start = 1; halt = 0; br_en = 0; b_taken = 0; br_idx = '0;
        tick(); tick();
        check("reset_pc", 32'(pc), 0);
        check("reset_done", 32'(done), 0);
        check("reset_running", 32'(running), 0);
        reset = 0;
        repeat (3) tick();
        check("idle_running", 32'(running), 0);
        check("idle_pc", 32'(pc), 0);
        start = 0;
        tick();
        check("start_fall_running", 32'(running), 1);
        check("first_fetch_pc", 32'(pc), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) check("second_fetch_pc", 32'(pc), 1);
        end
        check("seq_pc", 32'(pc), 10);
        check("seq_cycle", 32'(cyc), 10);
        check("seq_taken", 32'(tk), 0);
        start = 1; tick();
        check("restart_pc", 32'(pc), 0);
        check("restart_running", 32'(running), 0);
        start = 0; tick();
        repeat (5) tick();
        check("pre_branch_pc", 32'(pc), 5);
        br_en = 1; br_idx = 3; b_taken = 0; tick();
        check("untaken_pc", 32'(pc), 6);
        check("untaken_ct", 32'(tk), 0);
        b_taken = 1; tick();
        check("taken_pc", 32'(pc), 'h40);
        check("taken_ct", 32'(tk), 1);
        br_en = 0; tick();
        check("ignored_btaken_pc", 32'(pc), 'h41);
        check("ignored_btaken_ct", 32'(tk), 1);
        br_en = 1; br_idx = 2; tick();
        check("to_halt_pc", 32'(pc), 'h12);
        br_en = 0; b_taken = 0; halt = 1; tick();
        check("halt_done", 32'(done), 1);
        check("halt_pc", 32'(pc), 'h12);
        check("halt_cycle", 32'(cyc), 10);
        halt = 0; br_en = 1; b_taken = 1; br_idx = 3;
        repeat (5) tick();
        check("halted_pc", 32'(pc), 'h12);
        check("halted_cycle", 32'(cyc), 10);
        check("halted_taken", 32'(tk), 2);
        br_en = 0; b_taken = 0; start = 1; tick();
        check("unhalt_done", 32'(done), 0);
        check("unhalt_pc", 32'(pc), 0);
        start = 0; tick();
        br_en = 1; b_taken = 1; br_idx = 1; tick();
        check("top_pc", 32'(pc), 'h3FF);
        br_en = 0; b_taken = 0; tick();
        check("wrap_pc", 32'(pc), 0);
        repeat (20) tick();
        check("long_cycle16", 32'(cyc), 22);
        check("long_cycle4_sat", 32'(cyc4), 'hF);
        check("long_pc", 32'(pc), 20);
        br_en = 1; b_taken = 1; br_idx = 4; tick();
        check("pre_reset_pc", 32'(pc), 'h20);
        br_en = 0; b_taken = 0; reset = 1; tick();
        check("midrun_reset_pc", 32'(pc), 0);
        check("midrun_reset_running", 32'(running), 0);
        check("midrun_reset_cycle", 32'(cyc), 0);
        reset = 0; tick();
        check("rerun_running", 32'(running), 1);
        halt = 1; br_en = 1; b_taken = 1; br_idx = 3; tick();
        check("halt_over_branch_done", 32'(done), 1);
        check("halt_over_branch_pc", 32'(pc), 0);
        check("halt_over_branch_taken", 32'(tk), 0);
        halt = 0; br_en = 0; b_taken = 0; start = 1; tick();
        check("final_done", 32'(done), 0);
        check("final_running", 32'(running), 0);
        start = 0; tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
